reg_file_banked: RTL and testbench
==================================

// Module: reg_file_banked
// PURPOSE
// - Parametrised multi-read-port register file with a stall-hold read pipeline and hardware scrub after reset.
// - Successor to the single-port reg_file: configurable depth, width and read-port count.
// - Adds a registered read valid, optional register-0-is-zero, and an optional write-to-read bypass.
// - Sits between the pipeline decode stage (read addresses) and writeback (write port); stall comes from the hazard unit.
// PARAMETERS
// - NUM_REGS   10   number of entries (need not be a power of two)
// - DATA_W     32   entry width in bits
// - NUM_RD     2    number of independent read ports
// - ZERO_REG0  0    1: entry 0 always reads 0 and writes to it are dropped
// - AW (localparam) = max(1, $clog2(NUM_REGS)); address width
// PORTS
// - clk       in   1              single clock, all state on posedge
// - rst       in   1              synchronous, active-high reset
// - stall     in   1              1: hold read outputs
// - ready     out  1              1: scrub complete, port accepts traffic
// - wr_en     in   1              write strobe
// - wr_addr   in   AW             write address
// - wr_data   in   DATA_W         write data
// - rd_en     in   NUM_RD         per-port read request
// - rd_addr   in   NUM_RD*AW      port i at [i*AW +: AW]
// - rd_data   out  NUM_RD*DATA_W  port i at [i*DATA_W +: DATA_W]
// - rd_valid  out  NUM_RD         per-port data-valid
// BEHAVIOUR
// - FSM states: S_INIT, S_RUN. rst forces S_INIT, scrub ptr=0, ready=0, rd_data=0, rd_valid=0.
// - S_INIT: writes 0 to entry ptr each cycle and increments ptr.
//   - After writing entry NUM_REGS-1, moves to S_RUN and sets ready=1.
//   - ready rises exactly NUM_REGS cycles after the first cycle with rst low.
// - S_INIT ignores stall. wr_en is dropped. rd_valid stays 0.
// - rst asserted mid-scrub or mid-run restarts the scrub from entry 0.
// - S_RUN write: when wr_en=1 and wr_addr<NUM_REGS, the entry updates at the posedge.
//   - Dropped if wr_addr>=NUM_REGS, or if ZERO_REG0=1 and wr_addr==0.
//   - Writes commit regardless of stall.
// - S_RUN read, 1-cycle latency, when stall=0:
//   - rd_data[i] <= array[rd_addr[i]]
//   - rd_valid[i] <= rd_en[i]
//   - rd_data[i] is still updated when rd_en[i]=0.
// - Read address >= NUM_REGS returns 0. ZERO_REG0=1 with address 0 returns 0.
// - stall=1: rd_data and rd_valid hold their previous values. Read addresses are not sampled.
// - Same-cycle write and read to the same address: see CONFIGURATION.
// - All read ports may hit the same address in one cycle; each returns the same value.
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN.
//   - Defined: if wr_en commits to address A in the cycle port i samples A, rd_data[i] gets wr_data (new value).
//   - Not defined: rd_data[i] gets the pre-write array content (old value).
// - The bypass never applies to dropped writes (out of range, reg0 when ZERO_REG0=1, S_INIT).
// STRUCTURE
// - Package regfile_pkg:
//   - state enum {S_INIT, S_RUN}
//   - function addr_w(n) returning max(1, $clog2(n))
// - Sub-module regfile_rd_port: one per read port via generate.
//   - Holds the address-range/zero check, the bypass mux and the stall-hold output flops.
// - The top level owns the array, the FSM, the scrub pointer and the write-qualify logic.
// TESTING (NUM_REGS=10, DATA_W=32, NUM_RD=2, ZERO_REG0=1)
// - Reset/scrub:
//   - Release rst -> ready=0 for 10 cycles, then 1.
//   - Reads of all 10 entries return 0 with rd_valid=1 one cycle after rd_en.
// - Write/read:
//   - wr addr 3 = 0xDEADBEEF; next cycle rd_en[0]=1, rd_addr[0]=3.
//   - -> rd_data[0]=0xDEADBEEF, rd_valid[0]=1 one cycle later.
// - Stall hold:
//   - Read addr 3 (0xDEADBEEF), then stall=1 for 3 cycles while rd_addr[0]=5.
//   - -> rd_data[0] stays 0xDEADBEEF. After stall drops -> contents of entry 5.
// - Collision:
//   - wr addr 7 = 0x12345678 and rd addr 7 in the same cycle, entry 7 previously 0x1.
//   - -> 0x12345678 with REGFILE_BYPASS_EN defined, 0x1 without.
// - Boundaries:
//   - Write 0xFF to addr 0 and to addr 12 -> both dropped.
//   - Reads of addr 0 and addr 12 return 0.
//   - Both ports reading addr 3 together -> identical data.
// - Reset mid-operation:
//   - Assert rst for 1 cycle at scrub ptr=4, and again after writes.
//   - -> ready falls, scrub restarts from 0, ready back after 10 cycles, all entries read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the banked register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        S_INIT,
        S_RUN
    } state_e;

    // Address width for n entries, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w > 1) ? w : 1;
    endfunction

endpackage

// File: rtl/reg_file_banked_if.sv
// Pipeline-facing bus of the banked register file: stall/ready, one write port, NUM_RD read ports.
interface reg_file_banked_if
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned AW = addr_w(NUM_REGS);

    logic                     stall;
    logic                     ready;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;

    modport master (
        output stall, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  ready, rd_data, rd_valid
    );

    modport slave (
        input  stall, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output ready, rd_data, rd_valid
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One read port: range/reg0 check, optional write bypass (REGFILE_BYPASS_EN), stall-hold output flops.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ZERO_REG0 = 0,
    localparam int unsigned AW       = addr_w(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample,
    input  logic                       en,
    input  logic [AW-1:0]              addr,
    input  logic [NUM_REGS*DATA_W-1:0] mem,
    input  logic                       wr_commit,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          data,
    output logic                       valid
);
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Out-of-range addresses match no entry and fall through as zero.
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr == AW'(k)) begin
                word = mem[k*DATA_W +: DATA_W];
            end
        end
        if ((ZERO_REG0 != 0) && (addr == '0)) begin
            word = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_commit && (wr_addr == addr)) begin
            word = wr_data;
        end
`endif
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_commit, wr_addr, wr_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (sample) begin
            data_q  <= word;
            valid_q <= en;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/reg_file_banked.sv
// Multi-read-port register file with post-reset scrub and stall-hold reads.
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file_banked
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned ZERO_REG0 = 0
) (
    input logic              clk,
    input logic              rst,
    reg_file_banked_if.slave bus
);
    localparam int unsigned AW = addr_w(NUM_REGS);

    state_e                     state_q, state_d;
    logic [AW-1:0]              ptr_q;
    logic                       scrub_we;
    logic                       run;
    logic                       wr_in_range;
    logic                       wr_is_zero;
    logic                       wr_commit;
    logic [DATA_W-1:0]          mem [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] mem_flat;
    logic [DATA_W-1:0]          port_data [NUM_RD];
    logic [NUM_RD-1:0]          port_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (scrub_we) begin
                ptr_q <= ptr_q + AW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT: if (ptr_q == AW'(NUM_REGS - 1)) state_d = S_RUN;
            S_RUN:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        scrub_we = 1'b0;
        run      = 1'b0;
        unique case (state_q)
            S_INIT: scrub_we = 1'b1;
            S_RUN:  run      = 1'b1;
        endcase
    end

    assign bus.ready = run;

    assign wr_in_range = {1'b0, bus.wr_addr} < (AW + 1)'(NUM_REGS);
    assign wr_is_zero  = (ZERO_REG0 != 0) && (bus.wr_addr == '0);
    assign wr_commit   = run && bus.wr_en && wr_in_range && !wr_is_zero;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (scrub_we) begin
                mem[ptr_q] <= '0;
            end else if (wr_commit) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign mem_flat[k*DATA_W +: DATA_W] = mem[k];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .NUM_REGS  (NUM_REGS),
            .DATA_W    (DATA_W),
            .ZERO_REG0 (ZERO_REG0)
        ) u_rd_port (
            .clk       (clk),
            .rst       (rst),
            .sample    (run && !bus.stall),
            .en        (bus.rd_en[i]),
            .addr      (bus.rd_addr[i*AW +: AW]),
            .mem       (mem_flat),
            .wr_commit (wr_commit),
            .wr_addr   (bus.wr_addr),
            .wr_data   (bus.wr_data),
            .data      (port_data[i]),
            .valid     (port_valid[i])
        );
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = port_data[i];
        end
    end

    assign bus.rd_valid = port_valid;

endmodule

// File: tb/tb_reg_file_banked.sv
// Self-checking bench for reg_file_banked: directed scenarios plus random traffic against a model.
module tb_reg_file_banked;
    localparam int N  = 10;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_banked_if #(.NUM_REGS(N), .DATA_W(DW), .NUM_RD(NR)) bus ();

    reg_file_banked #(
        .NUM_REGS  (N),
        .DATA_W    (DW),
        .NUM_RD    (NR),
        .ZERO_REG0 (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: entries, cycles since reset release, expected read outputs.
    logic [DW-1:0] m_mem [N];
    logic [DW-1:0] exp_data [NR];
    logic [NR-1:0] exp_valid;
    int            m_cnt = 0;
    logic          m_on  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit write_lands();
        return bus.wr_en && (bus.wr_addr != 0) && (bus.wr_addr < N);
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = '0;
        if (a != 0 && a < N) v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (write_lands() && bus.wr_addr == a) v = bus.wr_data;
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on      <= 1'b1;
            m_cnt     <= 0;
            exp_valid <= '0;
            for (int k = 0; k < N; k++) m_mem[k] <= '0;
            for (int i = 0; i < NR; i++) exp_data[i] <= '0;
        end else if (m_on) begin
            if (m_cnt < N) begin
                m_cnt <= m_cnt + 1;
            end else begin
                if (!bus.stall) begin
                    for (int i = 0; i < NR; i++) begin
                        exp_data[i]  <= model_read(bus.rd_addr[i*AW +: AW]);
                        exp_valid[i] <= bus.rd_en[i];
                    end
                end
                if (write_lands()) m_mem[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model_ready", 64'(bus.ready), 64'(m_cnt >= N));
            for (int i = 0; i < NR; i++) begin
                chk("model_rd_valid", 64'(bus.rd_valid[i]), 64'(exp_valid[i]));
                chk("model_rd_data", 64'(bus.rd_data[i*DW +: DW]), 64'(exp_data[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = '0;
        bus.rd_addr = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.rd_en   = en;
        bus.rd_addr = {a1, a0};
    endtask

    function automatic logic [DW-1:0] port(input int i);
        return bus.rd_data[i*DW +: DW];
    endfunction

    initial begin
        int n;
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_ready", 64'(bus.ready), 64'(0));
        chk("reset_valid", 64'(bus.rd_valid), 64'(0));
        chk("reset_data", 64'(port(0)), 64'(0));

        // Scrub: ready low for exactly N cycles, writes during scrub dropped.
        rst = 1'b0;
        wr(4'd2, 32'h0BAD_0BAD);
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("scrub_ready", 64'(bus.ready), 64'(k == N));
        end
        idle();

        for (int a = 0; a < N; a++) begin
            rd(2'b11, 4'(a), 4'(N - 1 - a));
            tick();
            chk("scrub_valid", 64'(bus.rd_valid), 64'(2'b11));
            chk("scrub_p0", 64'(port(0)), 64'(0));
            chk("scrub_p1", 64'(port(1)), 64'(0));
        end
        idle();

        // Write then read, then stall hold.
        wr(4'd3, 32'hDEAD_BEEF);
        tick();
        wr(4'd5, 32'hA5A5_A5A5);
        rd(2'b01, 4'd3, 4'd0);
        tick();
        chk("wr_rd_data", 64'(port(0)), 64'(32'hDEAD_BEEF));
        chk("wr_rd_valid", 64'(bus.rd_valid), 64'(2'b01));
        bus.wr_en = 1'b0;
        bus.stall = 1'b1;
        rd(2'b01, 4'd5, 4'd0);
        repeat (3) begin
            tick();
            chk("stall_hold", 64'(port(0)), 64'(32'hDEAD_BEEF));
        end
        bus.stall = 1'b0;
        tick();
        chk("stall_release", 64'(port(0)), 64'(32'hA5A5_A5A5));

        // Collision on entry 7.
        idle();
        wr(4'd7, 32'h1);
        tick();
        wr(4'd7, 32'h1234_5678);
        rd(2'b01, 4'd7, 4'd0);
        tick();
`ifdef REGFILE_BYPASS_EN
        chk("collision", 64'(port(0)), 64'(32'h1234_5678));
`else
        chk("collision", 64'(port(0)), 64'(32'h1));
`endif
        bus.wr_en = 1'b0;
        tick();
        chk("collision_after", 64'(port(0)), 64'(32'h1234_5678));

        // Boundaries: reg0 and out-of-range writes dropped, reads return 0.
        idle();
        wr(4'd0, 32'hFF);
        tick();
        wr(4'd12, 32'hFF);
        tick();
        bus.wr_en = 1'b0;
        rd(2'b11, 4'd0, 4'd12);
        tick();
        chk("reg0_read", 64'(port(0)), 64'(0));
        chk("oor_read", 64'(port(1)), 64'(0));
        rd(2'b11, 4'd3, 4'd3);
        tick();
        chk("same_addr_p0", 64'(port(0)), 64'(32'hDEAD_BEEF));
        chk("same_addr_p1", 64'(port(1)), 64'(32'hDEAD_BEEF));

        // Reset mid-scrub at ptr=4.
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("midscrub_ready", 64'(bus.ready), 64'(0));
        rst = 1'b0;
        n = 0;
        while (!bus.ready && n < 50) begin
            tick();
            n++;
        end
        chk("midscrub_latency", 64'(n), 64'(N));

        // Reset after writes clears contents.
        wr(4'd3, 32'hCAFE_F00D);
        tick();
        bus.wr_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (N) tick();
        rd(2'b11, 4'd3, 4'd7);
        tick();
        chk("rst_clear_p0", 64'(port(0)), 64'(0));
        chk("rst_clear_p1", 64'(port(1)), 64'(0));

        // Random traffic with occasional stall and reset.
        for (int c = 0; c < 800; c++) begin
            rst         = ($urandom_range(0, 249) == 0);
            bus.stall   = ($urandom_range(0, 3) == 0);
            bus.wr_en   = $urandom_range(0, 1) == 1;
            bus.wr_addr = 4'($urandom_range(0, 15));
            bus.wr_data = $urandom;
            bus.rd_en   = 2'($urandom_range(0, 3));
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 2) == 0) bus.rd_addr[i*AW +: AW] = bus.wr_addr;
                else bus.rd_addr[i*AW +: AW] = 4'($urandom_range(0, 15));
            end
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
